leaf_rule_matcher: RTL and testbench

Sequential classifier for leaf nodes of the cut tree: accepts one 5-tuple packet plus one leaf's rule list, scans the rules LANES at a time, and returns the matching rule index and weight. Sits behind the tree walker, which hands it a leaf's rules once traversal ends. The result feeds the classification output stage. Field widths, rules per node, compare parallelism and match policy are parameters.

---
 rtl/network_pkg.sv | 42 ++++
 rtl/rule_range_cmp.sv | 45 ++++
 rtl/leaf_rule_matcher.sv | 183 ++++++++++++++++++
 tb/tb_leaf_rule_matcher.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Shared cut-tree types: default-width packet/rule layouts, match policies,
// width helpers and the leaf matcher state encoding.
package network_pkg;

    localparam int unsigned MATCH_FIRST      = 0;
    localparam int unsigned MATCH_MAX_WEIGHT = 1;

    localparam int unsigned IP_W_DEF    = 33;
    localparam int unsigned PORT_W_DEF  = 17;
    localparam int unsigned PROTO_W_DEF = 9;

    function automatic int unsigned pkt_width(input int unsigned ip_w,
                                              input int unsigned port_w,
                                              input int unsigned proto_w);
        return 2 * (ip_w + port_w) + proto_w;
    endfunction

    function automatic int unsigned rule_width(input int unsigned pkt_w);
        return 2 * pkt_w + 32;
    endfunction

    typedef struct packed {
        logic [IP_W_DEF-1:0]    src_ip;
        logic [PORT_W_DEF-1:0]  src_port;
        logic [IP_W_DEF-1:0]    dst_ip;
        logic [PORT_W_DEF-1:0]  dst_port;
        logic [PROTO_W_DEF-1:0] proto;
    } packet_s;

    typedef struct packed {
        packet_s     start;
        packet_s     last;
        logic [31:0] weight;
    } rule_s;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } match_state_e;

endpackage

// File: rtl/rule_range_cmp.sv
// One rule against one packet: every field must lie inside [start, last],
// unsigned and inclusive. Also exposes the rule's weight to the caller.
module rule_range_cmp
    import network_pkg::*;
#(
    parameter  int unsigned IP_W    = 33,
    parameter  int unsigned PORT_W  = 17,
    parameter  int unsigned PROTO_W = 9,
    localparam int unsigned PKT_W   = pkt_width(IP_W, PORT_W, PROTO_W),
    localparam int unsigned RULE_W  = rule_width(PKT_W)
) (
    input  logic [RULE_W-1:0] rule_i,
    input  logic [PKT_W-1:0]  pkt_i,
    output logic              match_o,
    output logic [31:0]       weight_o
);

    localparam int unsigned OFF_PROTO = 0;
    localparam int unsigned OFF_DPORT = PROTO_W;
    localparam int unsigned OFF_DIP   = OFF_DPORT + PORT_W;
    localparam int unsigned OFF_SPORT = OFF_DIP + IP_W;
    localparam int unsigned OFF_SIP   = OFF_SPORT + PORT_W;

    logic [PKT_W-1:0] lo;
    logic [PKT_W-1:0] hi;
    logic [4:0]       fld_ok;

    assign lo       = rule_i[RULE_W-1 -: PKT_W];
    assign hi       = rule_i[PKT_W+31 -: PKT_W];
    assign weight_o = rule_i[31:0];

    assign fld_ok[4] = (pkt_i[OFF_SIP +: IP_W] >= lo[OFF_SIP +: IP_W]) &&
                       (pkt_i[OFF_SIP +: IP_W] <= hi[OFF_SIP +: IP_W]);
    assign fld_ok[3] = (pkt_i[OFF_SPORT +: PORT_W] >= lo[OFF_SPORT +: PORT_W]) &&
                       (pkt_i[OFF_SPORT +: PORT_W] <= hi[OFF_SPORT +: PORT_W]);
    assign fld_ok[2] = (pkt_i[OFF_DIP +: IP_W] >= lo[OFF_DIP +: IP_W]) &&
                       (pkt_i[OFF_DIP +: IP_W] <= hi[OFF_DIP +: IP_W]);
    assign fld_ok[1] = (pkt_i[OFF_DPORT +: PORT_W] >= lo[OFF_DPORT +: PORT_W]) &&
                       (pkt_i[OFF_DPORT +: PORT_W] <= hi[OFF_DPORT +: PORT_W]);
    assign fld_ok[0] = (pkt_i[OFF_PROTO +: PROTO_W] >= lo[OFF_PROTO +: PROTO_W]) &&
                       (pkt_i[OFF_PROTO +: PROTO_W] <= hi[OFF_PROTO +: PROTO_W]);

    assign match_o = &fld_ok;

endmodule

// File: rtl/leaf_rule_matcher.sv
// Leaf classifier: scans a registered rule list LANES rules per cycle and
// reports the winning rule order and weight (first match or max weight).
module leaf_rule_matcher
    import network_pkg::*;
#(
    parameter  int unsigned IP_W      = 33,
    parameter  int unsigned PORT_W    = 17,
    parameter  int unsigned PROTO_W   = 9,
    parameter  int unsigned MAX_RULES = 16,
    parameter  int unsigned LANES     = 4,
    parameter  int unsigned MODE      = 0,
    localparam int unsigned PKT_W     = pkt_width(IP_W, PORT_W, PROTO_W),
    localparam int unsigned RULE_W    = rule_width(PKT_W),
    localparam int unsigned IDX_W     = (MAX_RULES > 1) ? $clog2(MAX_RULES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PKT_W-1:0]            in_pkt,
    input  logic [MAX_RULES*RULE_W-1:0] in_rules,
    input  logic [31:0]                 in_rule_count,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_hit,
    output logic [IDX_W-1:0]            out_index,
    output logic [31:0]                 out_weight
);

    localparam int unsigned NBEATS = (MAX_RULES + LANES - 1) / LANES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_RULES + 1);
    localparam int unsigned PAD    = NBEATS * LANES;

    match_state_e                state_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic [PKT_W-1:0]            pkt_q;
    logic [MAX_RULES*RULE_W-1:0] rules_q;
    logic [CNT_W-1:0]            count_q;
    logic [BEAT_W-1:0]           last_beat_q;
    logic [BEAT_W-1:0]           beat_q;
    logic                        hit_q;
    logic [IDX_W-1:0]            index_q;
    logic [31:0]                 weight_q;

    logic [CNT_W-1:0]            count_d;
    logic [BEAT_W-1:0]           last_beat_d;
    logic                        hit_d;
    logic [IDX_W-1:0]            index_d;
    logic [31:0]                 weight_d;

    logic [RULE_W-1:0]           rule_ord [PAD];
    logic [RULE_W-1:0]           lane_rule [LANES];
    logic [31:0]                 lane_w [LANES];
    logic [IDX_W-1:0]            lane_ord [LANES];
    logic [LANES-1:0]            lane_en;
    logic [LANES-1:0]            lane_match;

    // Order j lives in the top-down slot MAX_RULES-1-j; pad to whole beats.
    for (genvar j = 0; j < PAD; j++) begin : g_ord
        if (j < MAX_RULES) begin : g_real
            assign rule_ord[j] = rules_q[(MAX_RULES-1-j)*RULE_W +: RULE_W];
        end else begin : g_pad
            assign rule_ord[j] = '0;
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_rule[l] = '0;
            lane_en[l]   = 1'b0;
            lane_ord[l]  = '0;
            for (int unsigned b = 0; b < NBEATS; b++) begin
                if (beat_q == BEAT_W'(b)) begin
                    lane_rule[l] = rule_ord[b*LANES + l];
                    lane_en[l]   = (b*LANES + l) < 32'(count_q);
                    lane_ord[l]  = IDX_W'(b*LANES + l);
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        rule_range_cmp #(
            .IP_W    (IP_W),
            .PORT_W  (PORT_W),
            .PROTO_W (PROTO_W)
        ) u_cmp (
            .rule_i   (lane_rule[l]),
            .pkt_i    (pkt_q),
            .match_o  (lane_match[l]),
            .weight_o (lane_w[l])
        );
    end

    // Ascending lane walk on top of the running best: first hit sticks in
    // first-match mode, strictly greater weight replaces in max-weight mode.
    always_comb begin
        hit_d    = hit_q;
        index_d  = index_q;
        weight_d = weight_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_en[l] && lane_match[l]) begin
                if (!hit_d || (MODE == MATCH_MAX_WEIGHT && lane_w[l] > weight_d)) begin
                    hit_d    = 1'b1;
                    index_d  = lane_ord[l];
                    weight_d = lane_w[l];
                end
            end
        end
    end

    always_comb begin
        count_d     = (in_rule_count > 32'(MAX_RULES)) ? CNT_W'(MAX_RULES)
                                                       : CNT_W'(in_rule_count);
        last_beat_d = '0;
        for (int unsigned b = 1; b < NBEATS; b++) begin
            if (32'(count_d) > b*LANES) begin
                last_beat_d = BEAT_W'(b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
            rules_q     <= '0;
            count_q     <= '0;
            last_beat_q <= '0;
            beat_q      <= '0;
            hit_q       <= 1'b0;
            index_q     <= '0;
            weight_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q     <= ST_SCAN;
                        in_ready_q  <= 1'b0;
                        pkt_q       <= in_pkt;
                        rules_q     <= in_rules;
                        count_q     <= count_d;
                        last_beat_q <= last_beat_d;
                        beat_q      <= '0;
                        hit_q       <= 1'b0;
                        index_q     <= '0;
                        weight_q    <= '0;
                    end
                end
                ST_SCAN: begin
                    hit_q    <= hit_d;
                    index_q  <= index_d;
                    weight_q <= weight_d;
                    if (beat_q == last_beat_q || (MODE == MATCH_FIRST && hit_d)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_hit    = hit_q;
    assign out_index  = index_q;
    assign out_weight = weight_q;

endmodule

// File: tb/tb_leaf_rule_matcher.sv
// Drives a first-match and a max-weight matcher with identical requests and
// compares both against a rule-list reference model.
module tb_leaf_rule_matcher;
    import network_pkg::*;

    localparam int unsigned MAXR  = 16;
    localparam int unsigned LN    = 4;
    localparam int unsigned PKTW  = pkt_width(IP_W_DEF, PORT_W_DEF, PROTO_W_DEF);
    localparam int unsigned RULEW = rule_width(PKTW);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   out_ready;
    logic [PKTW-1:0]        in_pkt;
    logic [MAXR*RULEW-1:0]  in_rules;
    logic [31:0]            in_rule_count;
    logic                   in_ready0, in_ready1, out_valid0, out_valid1;
    logic                   out_hit0, out_hit1;
    logic [3:0]             out_index0, out_index1;
    logic [31:0]            out_weight0, out_weight1;

    always #5 clk = ~clk;

    leaf_rule_matcher #(
        .IP_W(33), .PORT_W(17), .PROTO_W(9), .MAX_RULES(MAXR), .LANES(LN), .MODE(MATCH_FIRST)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pkt(in_pkt), .in_rules(in_rules), .in_rule_count(in_rule_count),
        .out_valid(out_valid0), .out_ready(out_ready), .out_hit(out_hit0),
        .out_index(out_index0), .out_weight(out_weight0)
    );

    leaf_rule_matcher #(
        .IP_W(33), .PORT_W(17), .PROTO_W(9), .MAX_RULES(MAXR), .LANES(LN), .MODE(MATCH_MAX_WEIGHT)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_pkt(in_pkt), .in_rules(in_rules), .in_rule_count(in_rule_count),
        .out_valid(out_valid1), .out_ready(out_ready), .out_hit(out_hit1),
        .out_index(out_index1), .out_weight(out_weight1)
    );

    int          total = 0;
    int          bad   = 0;
    packet_s     pkt;
    rule_s       rl [MAXR];
    int unsigned cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rule_hits(input rule_s r, input packet_s p);
        return p.src_ip   >= r.start.src_ip   && p.src_ip   <= r.last.src_ip   &&
               p.src_port >= r.start.src_port && p.src_port <= r.last.src_port &&
               p.dst_ip   >= r.start.dst_ip   && p.dst_ip   <= r.last.dst_ip   &&
               p.dst_port >= r.start.dst_port && p.dst_port <= r.last.dst_port &&
               p.proto    >= r.start.proto    && p.proto    <= r.last.proto;
    endfunction

    // Expected result and latency (edges after accept) straight from the rule list.
    function automatic void model(input int unsigned mode, output bit hit,
                                  output int unsigned idx, output int unsigned w,
                                  output int unsigned lat);
        int unsigned n = (cnt > MAXR) ? MAXR : cnt;
        hit = 1'b0; idx = 0; w = 0;
        lat = (n == 0) ? 1 : (n + LN - 1) / LN;
        for (int unsigned j = 0; j < n; j++) begin
            if (rule_hits(rl[j], pkt)) begin
                if (mode == 0) begin
                    if (!hit) begin
                        hit = 1'b1; idx = j; w = rl[j].weight; lat = j / LN + 1;
                    end
                end else if (!hit || rl[j].weight > w) begin
                    hit = 1'b1; idx = j; w = rl[j].weight;
                end
            end
        end
    endfunction

    function automatic logic [63:0] rnd_field(input int unsigned w);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            default: ;
        endcase
        return r & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic new_pkt();
        pkt.src_ip   = 33'(rnd_field(33));
        pkt.src_port = 17'(rnd_field(17));
        pkt.dst_ip   = 33'(rnd_field(33));
        pkt.dst_port = 17'(rnd_field(17));
        pkt.proto    = 9'(rnd_field(9));
    endtask

    task automatic mk_range(input logic [63:0] v, input int unsigned w, input bit miss,
                            output logic [63:0] lo, output logic [63:0] hi);
        logic [63:0] mx, d1, d2;
        mx = (64'd1 << w) - 64'd1;
        d1 = 64'($urandom_range(0, 3));
        d2 = 64'($urandom_range(0, 3));
        lo = (v >= d1) ? v - d1 : '0;
        hi = (mx - v >= d2) ? v + d2 : mx;
        if (miss) begin
            if (v < mx) begin
                lo = v + 64'd1;
                hi = (mx - lo >= d2) ? lo + d2 : mx;
            end else begin
                hi = v - 64'd1;
                lo = (hi >= d1) ? hi - d1 : '0;
            end
        end
    endtask

    task automatic make_rule(input int unsigned j, input bit miss, input int unsigned w);
        logic [63:0] lo, hi;
        int unsigned bf;
        bf = miss ? $urandom_range(0, 4) : 5;
        mk_range(64'(pkt.src_ip), 33, bf == 0, lo, hi);
        rl[j].start.src_ip = 33'(lo);   rl[j].last.src_ip = 33'(hi);
        mk_range(64'(pkt.src_port), 17, bf == 1, lo, hi);
        rl[j].start.src_port = 17'(lo); rl[j].last.src_port = 17'(hi);
        mk_range(64'(pkt.dst_ip), 33, bf == 2, lo, hi);
        rl[j].start.dst_ip = 33'(lo);   rl[j].last.dst_ip = 33'(hi);
        mk_range(64'(pkt.dst_port), 17, bf == 3, lo, hi);
        rl[j].start.dst_port = 17'(lo); rl[j].last.dst_port = 17'(hi);
        mk_range(64'(pkt.proto), 9, bf == 4, lo, hi);
        rl[j].start.proto = 9'(lo);     rl[j].last.proto = 9'(hi);
        rl[j].weight = w;
    endtask

    task automatic scramble_inputs();
        in_pkt = PKTW'({$urandom, $urandom, $urandom, $urandom});
        for (int unsigned k = 0; k < MAXR*RULEW/32 + 1; k++)
            in_rules = {in_rules[MAXR*RULEW-33:0], 32'($urandom)};
        in_rule_count = $urandom;
    endtask

    task automatic accept_req();
        in_pkt        = pkt;
        in_rule_count = cnt;
        for (int unsigned j = 0; j < MAXR; j++)
            in_rules[(MAXR-1-j)*RULEW +: RULEW] = rl[j];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rdy0"}, 64'(in_ready0), 64'd1);
        check({tag, ".vld0"}, 64'(out_valid0), 64'd0);
        check({tag, ".hit0"}, 64'(out_hit0), 64'd0);
        check({tag, ".idx0"}, 64'(out_index0), 64'd0);
        check({tag, ".w0"},   64'(out_weight0), 64'd0);
        check({tag, ".rdy1"}, 64'(in_ready1), 64'd1);
        check({tag, ".vld1"}, 64'(out_valid1), 64'd0);
        check({tag, ".hit1"}, 64'(out_hit1), 64'd0);
        check({tag, ".idx1"}, 64'(out_index1), 64'd0);
        check({tag, ".w1"},   64'(out_weight1), 64'd0);
    endtask

    task automatic check_out(input string tag, input int unsigned m, input bit eh,
                             input int unsigned ei, input int unsigned ew);
        check({tag, ".hit"}, 64'(m == 0 ? out_hit0 : out_hit1), 64'(eh));
        check({tag, ".idx"}, 64'(m == 0 ? out_index0 : out_index1), 64'(ei));
        check({tag, ".w"},   64'(m == 0 ? out_weight0 : out_weight1), 64'(ew));
    endtask

    task automatic wait_res(input string tag, input int unsigned m, input bit eh,
                            input int unsigned ei, input int unsigned ew, input int unsigned el);
        int unsigned k = 0;
        bit seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            seen = (m == 0) ? out_valid0 : out_valid1;
        end
        check({tag, ".lat"}, 64'(seen ? k : 999), 64'(el));
        check_out(tag, m, eh, ei, ew);
    endtask

    task automatic run_txn(input int unsigned hold, input string name);
        bit eh0, eh1;
        int unsigned ei0, ei1, ew0, ew1, el0, el1;
        model(0, eh0, ei0, ew0, el0);
        model(1, eh1, ei1, ew1, el1);
        @(negedge clk);
        check({name, ".rdy0"}, 64'(in_ready0), 64'd1);
        check({name, ".rdy1"}, 64'(in_ready1), 64'd1);
        accept_req();
        fork
            wait_res({name, ".m0"}, 0, eh0, ei0, ew0, el0);
            wait_res({name, ".m1"}, 1, eh1, ei1, ew1, el1);
        join
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_rule_count = 0;
            @(posedge clk);
            #1;
            check({name, ".stall.vld0"}, 64'(out_valid0), 64'd1);
            check({name, ".stall.rdy0"}, 64'(in_ready0), 64'd0);
            check_out({name, ".stall.m0"}, 0, eh0, ei0, ew0);
            check({name, ".stall.vld1"}, 64'(out_valid1), 64'd1);
            check({name, ".stall.rdy1"}, 64'(in_ready1), 64'd0);
            check_out({name, ".stall.m1"}, 1, eh1, ei1, ew1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, ".rel.vld0"}, 64'(out_valid0), 64'd0);
        check({name, ".rel.rdy0"}, 64'(in_ready0), 64'd1);
        check({name, ".rel.vld1"}, 64'(out_valid1), 64'd0);
        check({name, ".rel.rdy1"}, 64'(in_ready1), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pkt = '0; in_rules = '0; in_rule_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // only orders 2 and 5 match; unpopulated slots match but must be masked
        new_pkt();
        cnt = 6;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, j < 6, $urandom_range(0, 9));
        make_rule(2, 1'b0, 3);
        make_rule(5, 1'b0, 8);
        run_txn(0, "first2");

        new_pkt();
        cnt = 6;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, j < 6, 100);
        make_rule(1, 1'b0, 7);
        make_rule(4, 1'b0, 9);
        make_rule(5, 1'b0, 9);
        run_txn(0, "maxw");

        new_pkt();
        cnt = 0;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, 1'b0, 5);
        run_txn(0, "n0");

        new_pkt();
        cnt = 40;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, 1'b1, 5);
        run_txn(0, "n40");

        // exact-bound ranges: field == start == last matches, field == last+1 misses
        new_pkt();
        pkt.dst_port = 17'h1FFFF;
        pkt.src_ip   = 33'd5;
        cnt = 1;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, 1'b1, 2);
        rl[0].start = pkt; rl[0].last = pkt; rl[0].weight = 11;
        run_txn(0, "bnd.eq");
        rl[0].last.dst_port = 17'h1FFFE;
        run_txn(0, "bnd.dport");
        rl[0].last.dst_port = 17'h1FFFF;
        rl[0].start.src_ip  = 33'd6;
        run_txn(0, "bnd.sip");

        new_pkt();
        cnt = 10;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, $urandom_range(0, 1) == 0, $urandom_range(0, 5));
        run_txn(5, "stall");

        new_pkt();
        cnt = 16;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, 1'b1, 3);
        @(negedge clk);
        accept_req();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        new_pkt();
        cnt = 9;
        for (int unsigned j = 0; j < MAXR; j++) make_rule(j, $urandom_range(0, 2) != 0, $urandom_range(0, 5));
        run_txn(0, "postreset");

        for (int unsigned t = 0; t < 80; t++) begin
            new_pkt();
            cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 60) : $urandom_range(0, 16);
            for (int unsigned j = 0; j < MAXR; j++)
                make_rule(j, $urandom_range(0, 9) < 7, $urandom_range(0, 5));
            run_txn($urandom_range(0, 2), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
